// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
//   state_e    : controller FSM states
//   BUF_DEPTH  : entries in the output skid buffer
//   OCC_WIDTH  : width of an occupancy count 0..BUF_DEPTH
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush,
    StDone
  } state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry synchronous FIFO used as the reader's output buffer.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i at the tail this cycle
//   push_data_i  : word to write
//   pop_i        : drop the head entry this cycle (ignored when empty)
//   occ_o        : current number of stored entries
//   head_o       : oldest stored entry
module stream_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [OCC_WIDTH-1:0]  occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (occ_q != '0);
    // A push into a full buffer is only legal if the head leaves in the same cycle.
    do_push = push_i && ((occ_q != OCC_WIDTH'(BUF_DEPTH)) || do_pop);
    // Depth is a power of two, so pointers wrap naturally.
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    occ_d    = occ_q + OCC_WIDTH'(do_push) - OCC_WIDTH'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO with one-cycle registered read data.
// A start command pops exactly len words and forwards them on a valid/ready stream
// through a two-entry buffer; done pulses once the last word is accepted.
//   clk, rst    : clock, synchronous active-high reset
//   start, len  : drain command and word count (sampled only in idle)
//   busy, done  : not idle / one-cycle completion pulse
//   fifo_rden   : pop request; fifo_data valid the following cycle
//   fifo_data   : FIFO read data
//   fifo_empty  : FIFO empty flag
//   m_valid, m_data, m_ready : output stream
//   words_out   : words accepted downstream in the current or last drain
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [LEN_WIDTH-1:0]  words_out
);

  localparam int unsigned CredW = OCC_WIDTH + 1;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  words_out_q, words_out_d;
  logic                  inflight_q, inflight_d;
  logic [OCC_WIDTH-1:0]  occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop_now;
  logic [CredW-1:0]      used_next;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_data),
    .pop_i       (pop_now),
    .occ_o       (occ),
    .head_o      (head)
  );

  always_comb begin
    pop_now   = (occ != '0) && m_ready;
    // Buffer slots committed after this cycle, ignoring any new pop: stored words plus
    // the word arriving from the FIFO, minus the one leaving downstream.
    used_next = CredW'(occ) + CredW'(inflight_q) - CredW'(pop_now);
    fifo_rden = (state_q == StDrain) && !fifo_empty && (remaining_q != '0) &&
                (used_next < CredW'(BUF_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q - LEN_WIDTH'(fifo_rden);
    words_out_d = words_out_q + LEN_WIDTH'(pop_now);
    inflight_d  = fifo_rden;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          words_out_d = '0;
          if (len != '0) begin
            state_d     = StDrain;
            remaining_d = len;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDrain: begin
        if (remaining_q == '0) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        // No pops happen here, so used_next is next-cycle occupancy plus in-flight.
        if (used_next == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      words_out_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      words_out_q <= words_out_d;
      inflight_q  <= inflight_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign m_valid   = (occ != '0);
  assign m_data    = head;
  assign words_out = words_out_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A behavioural FIFO keeps a log of every
// word ever pushed; the stream must reproduce that log in order, one drain at a time.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, fifo_rden, fifo_empty, m_valid;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [LW-1:0] words_out;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .fifo_rden  (fifo_rden),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .words_out  (words_out)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: fmem is the full push log, frd/fwr are pop/push counts.
  logic [DW-1:0] fmem [0:4095];
  int fwr = 0;
  int frd = 0;
  assign fifo_empty = (fwr == frd);

  always @(posedge clk) begin
    if (fifo_rden && (fwr != frd)) begin
      fifo_data <= fmem[12'(frd)];
      frd       <= frd + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_idx  = 0;
  int done_cnt = 0;
  int rden_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fmem[12'(fwr)] = d;
    fwr++;
  endtask

  // Per-cycle stream monitor, sampled mid-cycle before the active edge.
  task automatic mon();
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    check_eq("rden_while_empty", 32'(fifo_rden & fifo_empty), 32'd0);
    if (fifo_rden) rden_cnt++;
    if (prev_stall) begin
      check_eq("stall_valid", 32'(m_valid), 32'd1);
      check_eq("stall_data", 32'(m_data), 32'(prev_data));
    end
    if (m_valid && m_ready) begin
      check_eq("word_exists", 32'(exp_idx < fwr), 32'd1);
      check_eq("stream_data", 32'(m_data), 32'(fmem[12'(exp_idx)]));
      exp_idx++;
    end
    if (done) done_cnt++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  task automatic tick();
    #2;
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic start_drain(input int n);
    start = 1'b1;
    len   = LW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready, input int to_push);
    int pushed = 0;
    int i = 0;
    while (busy && i < budget) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      if (pushed < to_push && $urandom_range(0, 1) == 1) begin
        push_word(8'($urandom));
        pushed++;
      end
      tick();
      i++;
    end
    check_eq("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, rd_base, n, avail, need, pre;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rden", 32'(fifo_rden), 32'd0);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    check_eq("rst_words", 32'(words_out), 32'd0);
    rst = 1'b0;
    tick();

    // 1: exact latency and throughput with m_ready held high
    for (int i = 1; i <= 4; i++) push_word(8'(17 * i));
    m_ready = 1'b1; base = exp_idx; done_cnt = 0;
    start_drain(4);
    for (int c = 1; c <= 8; c++) begin
      #1;
      check_eq("t1_rden", 32'(fifo_rden), 32'(c <= 4));
      check_eq("t1_valid", 32'(m_valid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check_eq("t1_data", 32'(m_data), 32'(17 * (c - 2)));
      check_eq("t1_done", 32'(done), 32'(c == 7));
      check_eq("t1_busy", 32'(busy), 32'(c <= 7));
      if (c == 7) check_eq("t1_words", 32'(words_out), 32'd4);
      tick();
    end
    check_eq("t1_delivered", 32'(exp_idx - base), 32'd4);
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: backpressure caps pops at the buffer depth and holds the head
    for (int i = 1; i <= 4; i++) push_word(8'(17 * i));
    m_ready = 1'b0; base = exp_idx; done_cnt = 0; rden_cnt = 0;
    start_drain(4);
    for (int c = 0; c < 10; c++) tick();
    #1;
    check_eq("t2_rden_cnt", 32'(rden_cnt), 32'd2);
    check_eq("t2_valid", 32'(m_valid), 32'd1);
    check_eq("t2_head", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    wait_idle(50, 1'b0, 0);
    check_eq("t2_delivered", 32'(exp_idx - base), 32'd4);
    check_eq("t2_words", 32'(words_out), 32'd4);
    check_eq("t2_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t2_fifo_left", 32'(fwr - frd), 32'd0);

    // 3: start on an empty FIFO waits for data without popping
    m_ready = 1'b1; base = exp_idx; done_cnt = 0; rden_cnt = 0;
    start_drain(3);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("t3_busy", 32'(busy), 32'd1);
      tick();
    end
    check_eq("t3_no_rden", 32'(rden_cnt), 32'd0);
    push_word(8'hA0); tick(); tick(); tick();
    push_word(8'hA1); tick(); tick();
    push_word(8'hA2);
    wait_idle(50, 1'b0, 0);
    check_eq("t3_delivered", 32'(exp_idx - base), 32'd3);
    check_eq("t3_last_word", 32'(fmem[12'(exp_idx - 1)]), 32'hA2);
    check_eq("t3_words", 32'(words_out), 32'd3);
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd1);

    // 4: zero-length drain completes immediately
    done_cnt = 0; rden_cnt = 0;
    start_drain(0);
    #1;
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_words", 32'(words_out), 32'd0);
    tick();
    check_eq("t4_done_low", 32'(done), 32'd0);
    check_eq("t4_idle", 32'(busy), 32'd0);
    check_eq("t4_no_rden", 32'(rden_cnt), 32'd0);
    check_eq("t4_done_cnt", 32'(done_cnt), 32'd1);

    // 5: start while busy is ignored
    for (int i = 0; i < 6; i++) push_word(8'(8'h50 + i));
    m_ready = 1'b1; base = exp_idx; done_cnt = 0;
    start_drain(4);
    tick();
    start = 1'b1; len = LW'(2);
    tick();
    start = 1'b0;
    wait_idle(60, 1'b0, 0);
    check_eq("t5_delivered", 32'(exp_idx - base), 32'd4);
    check_eq("t5_fifo_left", 32'(fwr - frd), 32'd2);
    check_eq("t5_words", 32'(words_out), 32'd4);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd1);
    start_drain(2);
    wait_idle(60, 1'b0, 0);
    check_eq("t5_cleanup", 32'(fwr - frd), 32'd0);

    // 6: synchronous reset mid-drain; popped-but-uncaptured words are lost
    for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
    m_ready = 1'b1; rd_base = frd;
    start_drain(4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_rden", 32'(fifo_rden), 32'd0);
    check_eq("t6_valid", 32'(m_valid), 32'd0);
    check_eq("t6_data", 32'(m_data), 32'd0);
    check_eq("t6_words", 32'(words_out), 32'd0);
    check_eq("t6_popped", 32'(frd - rd_base), 32'd2);
    exp_idx = frd;
    base = exp_idx; done_cnt = 0;
    start_drain(1);
    wait_idle(40, 1'b0, 0);
    check_eq("t6_restart_delivered", 32'(exp_idx - base), 32'd1);
    check_eq("t6_restart_data", 32'(fmem[12'(base)]), 32'hC2);
    check_eq("t6_restart_words", 32'(words_out), 32'd1);
    check_eq("t6_restart_done", 32'(done_cnt), 32'd1);

    // Randomized drains with random backpressure and late-arriving data
    for (int it = 0; it < 25; it++) begin
      base = exp_idx; done_cnt = 0;
      n = $urandom_range(1, 10);
      avail = fwr - frd;
      need = (n > avail) ? n - avail : 0;
      pre = $urandom_range(0, need);
      for (int k = 0; k < pre; k++) push_word(8'($urandom));
      if ($urandom_range(0, 3) == 0) push_word(8'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      start_drain(n);
      wait_idle(400, 1'b1, need - pre);
      check_eq("rand_delivered", 32'(exp_idx - base), 32'(n));
      check_eq("rand_words", 32'(words_out), 32'(n));
      check_eq("rand_done_cnt", 32'(done_cnt), 32'd1);
      check_eq("rand_pops", 32'(frd), 32'(exp_idx));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
